// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Grants buffered functional-unit results onto the common data bus.
//   Every FU owns a one-entry holding buffer filled through a valid/ready
//   handshake. Each cycle up to NUM_CDB full buffers are granted in
//   round-robin order, starting at rr_ptr_q, and loaded into registered
//   CDB lanes (lane 0 takes the first grant in scan order).
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous active-high reset
//   stop_i         global stall: no grants, no accepts, everything holds
//   flush_i        squash all buffered and broadcasting results
//   fu_valid_i     per-FU result present
//   fu_ready_o     per-FU result accepted on this edge when valid
//   fu_tag_i       per-FU destination physical tag
//   fu_data_i      per-FU result value
//   fu_rob_tag_i   per-FU ROB entry
//   cdb_valid_o    per-lane broadcast valid (registered)
//   cdb_tag_o      per-lane physical tag (registered)
//   cdb_data_o     per-lane result value (registered)
//   cdb_rob_tag_o  per-lane ROB entry (registered)
module cdb_arbiter #(
    parameter int NUM_FU  = 6,
    parameter int NUM_CDB = 4,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 7
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stop_i,
    input  logic              flush_i,
    input  logic [NUM_FU-1:0] fu_valid_i,
    output logic [NUM_FU-1:0] fu_ready_o,
    input  logic [TAG_W-1:0]  fu_tag_i     [NUM_FU],
    input  logic [DATA_W-1:0] fu_data_i    [NUM_FU],
    input  logic [ROB_W-1:0]  fu_rob_tag_i [NUM_FU],
    output logic [NUM_CDB-1:0] cdb_valid_o,
    output logic [TAG_W-1:0]  cdb_tag_o     [NUM_CDB],
    output logic [DATA_W-1:0] cdb_data_o    [NUM_CDB],
    output logic [ROB_W-1:0]  cdb_rob_tag_o [NUM_CDB]
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(NUM_CDB + 1);
    localparam logic [PTR_W:0] NUM_FU_X = (PTR_W + 1)'(NUM_FU);

    logic [NUM_FU-1:0]  buf_valid_q;
    logic [TAG_W-1:0]   buf_tag_q  [NUM_FU];
    logic [DATA_W-1:0]  buf_data_q [NUM_FU];
    logic [ROB_W-1:0]   buf_rob_q  [NUM_FU];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_CDB-1:0] cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q  [NUM_CDB];
    logic [DATA_W-1:0]  cdb_data_q [NUM_CDB];
    logic [ROB_W-1:0]   cdb_rob_q  [NUM_CDB];

    logic [NUM_CDB-1:0] lane_use_d;
    logic [TAG_W-1:0]   lane_tag_d  [NUM_CDB];
    logic [DATA_W-1:0]  lane_data_d [NUM_CDB];
    logic [ROB_W-1:0]   lane_rob_d  [NUM_CDB];

    logic [NUM_FU-1:0]  grant;
    logic               active;
    logic               any_grant;
    logic [PTR_W-1:0]   last_idx;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W:0]     idx_sum;
    logic [CNT_W-1:0]   cnt;

    // Reset is folded in so fu_ready_o reads 0 while reset is held.
    assign active = !reset_i && !stop_i && !flush_i;

    // Round-robin scan: position j looks at FU (rr_ptr + j) mod NUM_FU; the
    // cnt-th full buffer found goes to lane cnt until the lanes run out.
    always_comb begin
        grant      = '0;
        lane_use_d = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_tag_d[k]  = '0;
            lane_data_d[k] = '0;
            lane_rob_d[k]  = '0;
        end
        cnt       = '0;
        idx_sum   = '0;
        idx       = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr_q;
        for (int j = 0; j < NUM_FU; j++) begin
            idx_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(j);
            if (idx_sum >= NUM_FU_X) begin
                idx_sum = idx_sum - NUM_FU_X;
            end
            idx = idx_sum[PTR_W-1:0];
            if (active && buf_valid_q[idx] && (cnt < CNT_W'(NUM_CDB))) begin
                grant[idx] = 1'b1;
                any_grant  = 1'b1;
                last_idx   = idx;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        lane_use_d[k]  = 1'b1;
                        lane_tag_d[k]  = buf_tag_q[idx];
                        lane_data_d[k] = buf_data_q[idx];
                        lane_rob_d[k]  = buf_rob_q[idx];
                    end
                end
                cnt = cnt + CNT_W'(1);
            end
        end

        // Pointer moves past the last winner; wraps at NUM_FU, not 2**PTR_W.
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    // A buffer being drained this edge can take a new result at the same time.
    assign fu_ready_o = active ? (~buf_valid_q | grant) : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_valid_q <= '0;
            cdb_valid_q <= '0;
            rr_ptr_q    <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_tag_q[k]  <= '0;
                cdb_data_q[k] <= '0;
                cdb_rob_q[k]  <= '0;
            end
        end else if (flush_i) begin
            buf_valid_q <= '0;
            cdb_valid_q <= '0;
        end else if (!stop_i) begin
            cdb_valid_q <= lane_use_d;
            for (int k = 0; k < NUM_CDB; k++) begin
                if (lane_use_d[k]) begin
                    cdb_tag_q[k]  <= lane_tag_d[k];
                    cdb_data_q[k] <= lane_data_d[k];
                    cdb_rob_q[k]  <= lane_rob_d[k];
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid_i[i] && fu_ready_o[i]) begin
                    buf_valid_q[i] <= 1'b1;
                    buf_tag_q[i]   <= fu_tag_i[i];
                    buf_data_q[i]  <= fu_data_i[i];
                    buf_rob_q[i]   <= fu_rob_tag_i[i];
                end else if (grant[i]) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_tag_o     = cdb_tag_q;
    assign cdb_data_o    = cdb_data_q;
    assign cdb_rob_tag_o = cdb_rob_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NF = 6;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset, stop, flush;
    logic [NF-1:0] fu_valid;
    logic [NF-1:0] fu_ready;
    logic [7:0]    fu_tag     [NF];
    logic [31:0]   fu_data    [NF];
    logic [6:0]    fu_rob_tag [NF];
    logic [NC-1:0] cdb_valid;
    logic [7:0]    cdb_tag     [NC];
    logic [31:0]   cdb_data    [NC];
    logic [6:0]    cdb_rob_tag [NC];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .stop_i       (stop),
        .flush_i      (flush),
        .fu_valid_i   (fu_valid),
        .fu_ready_o   (fu_ready),
        .fu_tag_i     (fu_tag),
        .fu_data_i    (fu_data),
        .fu_rob_tag_i (fu_rob_tag),
        .cdb_valid_o  (cdb_valid),
        .cdb_tag_o    (cdb_tag),
        .cdb_data_o   (cdb_data),
        .cdb_rob_tag_o(cdb_rob_tag)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: buffers, lanes and pointer as plain arrays/ints.
    bit          m_bv [NF];
    logic [7:0]  m_bt [NF];
    logic [31:0] m_bd [NF];
    logic [6:0]  m_br [NF];
    int          m_rr;
    bit          m_cv [NC];
    logic [7:0]  m_ct [NC];
    logic [31:0] m_cd [NC];
    logic [6:0]  m_cr [NC];
    int          g_fu [NC];
    int          g_n;
    bit          acc  [NF];
    int          seq = 0;

    function automatic void scan();
        g_n = 0;
        if (!(reset || stop || flush)) begin
            for (int j = 0; j < NF; j++) begin
                int f;
                f = (m_rr + j) % NF;
                if (m_bv[f] && g_n < NC) begin
                    g_fu[g_n] = f;
                    g_n++;
                end
            end
        end
    endfunction

    function automatic bit granted(input int f);
        for (int n = 0; n < g_n; n++) if (g_fu[n] == f) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        logic [NF-1:0] er;
        logic [NC-1:0] ev;
        #1;
        scan();
        for (int f = 0; f < NF; f++) er[f] = !(reset || stop || flush) && (!m_bv[f] || granted(f));
        chk("fu_ready", 64'(fu_ready), 64'(er));
        for (int f = 0; f < NF; f++) acc[f] = fu_valid[f] && er[f];
        @(posedge clk);
        if (reset) begin
            m_rr = 0;
            for (int f = 0; f < NF; f++) m_bv[f] = 0;
            for (int k = 0; k < NC; k++) begin
                m_cv[k] = 0; m_ct[k] = '0; m_cd[k] = '0; m_cr[k] = '0;
            end
        end else if (flush) begin
            for (int f = 0; f < NF; f++) m_bv[f] = 0;
            for (int k = 0; k < NC; k++) m_cv[k] = 0;
        end else if (!stop) begin
            for (int k = 0; k < NC; k++) begin
                m_cv[k] = (k < g_n);
                if (k < g_n) begin
                    m_ct[k] = m_bt[g_fu[k]];
                    m_cd[k] = m_bd[g_fu[k]];
                    m_cr[k] = m_br[g_fu[k]];
                end
            end
            for (int f = 0; f < NF; f++) begin
                if (acc[f]) begin
                    m_bv[f] = 1; m_bt[f] = fu_tag[f]; m_bd[f] = fu_data[f]; m_br[f] = fu_rob_tag[f];
                end else if (granted(f)) begin
                    m_bv[f] = 0;
                end
            end
            if (g_n > 0) m_rr = (g_fu[g_n-1] + 1) % NF;
        end
        #1;
        for (int k = 0; k < NC; k++) ev[k] = m_cv[k];
        chk("cdb_valid", 64'(cdb_valid), 64'(ev));
        for (int k = 0; k < NC; k++)
            if (m_cv[k] || reset)
                chk($sformatf("lane%0d", k), 64'({cdb_tag[k], cdb_data[k], cdb_rob_tag[k]}),
                    64'({m_ct[k], m_cd[k], m_cr[k]}));
    endtask

    task automatic new_result(input int f);
        logic [4:0] s;
        s = 5'(seq);
        seq++;
        fu_valid[f]   = 1'b1;
        fu_tag[f]     = {3'(f), s};
        fu_data[f]    = $urandom;
        fu_rob_tag[f] = 7'($urandom_range(0, 127));
    endtask

    // New results only where the previous one was taken (inputs hold otherwise).
    task automatic refill(input logic [NF-1:0] mask);
        for (int f = 0; f < NF; f++)
            if (!fu_valid[f] || acc[f]) begin
                if (mask[f]) new_result(f);
                else fu_valid[f] = 1'b0;
            end
    endtask

    task automatic do_reset();
        reset = 1; stop = 0; flush = 0; fu_valid = '0;
        step();
        reset = 0;
    endtask

    function automatic logic [2:0] lane_fu(input int k);
        logic [7:0] t;
        t = cdb_tag[k];
        return t[7:5];
    endfunction

    initial begin
        reset = 1; stop = 0; flush = 0; fu_valid = '0;
        for (int f = 0; f < NF; f++) begin
            fu_tag[f] = '0; fu_data[f] = '0; fu_rob_tag[f] = '0; acc[f] = 0;
            m_bv[f] = 0; m_bt[f] = '0; m_bd[f] = '0; m_br[f] = '0;
        end
        for (int k = 0; k < NC; k++) begin
            m_cv[k] = 0; m_ct[k] = '0; m_cd[k] = '0; m_cr[k] = '0;
        end
        m_rr = 0;
        step();
        step();
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        reset = 0;
        #1;
        chk("rst_ready_ones", 64'(fu_ready), 64'h3F);
        step();

        // single result from FU2
        fu_valid = 6'b000100;
        fu_tag[2] = 8'h15; fu_data[2] = 32'hDEADBEEF; fu_rob_tag[2] = 7'h03;
        step();
        fu_valid = '0;
        step();
        chk("single_valid", 64'(cdb_valid), 64'b0001);
        chk("single_lane0", 64'({cdb_tag[0], cdb_data[0], cdb_rob_tag[0]}), 64'({8'h15, 32'hDEADBEEF, 7'h03}));
        step();
        chk("single_once", 64'(cdb_valid), 64'h0);
        // rr_ptr=3: FU4 must beat FU0
        new_result(0); new_result(4);
        step();
        fu_valid = '0;
        step();
        chk("rr3_lane0", 64'(lane_fu(0)), 64'd4);
        chk("rr3_lane1", 64'(lane_fu(1)), 64'd0);

        // all six FUs continuously from rr_ptr=0
        do_reset();
        refill(6'h3F); step();
        refill(6'h3F); step();
        for (int k = 0; k < NC; k++) chk("all_c1", 64'(lane_fu(k)), 64'(k));
        refill(6'h3F); step();
        for (int k = 0; k < NC; k++) chk("all_c2", 64'(lane_fu(k)), 64'((k + 4) % NF));
        refill(6'h3F); step();
        for (int k = 0; k < NC; k++) chk("all_c3", 64'(lane_fu(k)), 64'(k + 2));
        for (int c = 0; c < 6; c++) begin refill(6'h3F); step(); end
        for (int c = 0; c < 4; c++) begin refill(6'h00); step(); end

        // back-to-back from FU0
        do_reset();
        fu_valid = 6'b000001; fu_tag[0] = 8'd1; step();
        fu_tag[0] = 8'd2; step();
        chk("b2b_t1", 64'(cdb_tag[0]), 64'd1);
        fu_tag[0] = 8'd3; step();
        chk("b2b_t2", 64'(cdb_tag[0]), 64'd2);
        chk("b2b_ready", 64'(fu_ready[0]), 64'd1);
        fu_valid = '0; step();
        chk("b2b_t3", 64'(cdb_tag[0]), 64'd3);
        chk("b2b_v3", 64'(cdb_valid), 64'b0001);

        // stop with lanes 0011 and buffers occupied
        do_reset();
        new_result(0); new_result(1); step();
        fu_valid = '0; new_result(2); new_result(3); step();
        fu_valid = '0; new_result(4);
        stop = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stop_valid", 64'(cdb_valid), 64'b0011);
            chk("stop_ready", 64'(fu_ready), 64'h0);
        end
        stop = 0;
        step();
        chk("unstop_valid", 64'(cdb_valid), 64'b0011);
        chk("unstop_l0", 64'(lane_fu(0)), 64'd2);
        chk("unstop_l1", 64'(lane_fu(1)), 64'd3);
        refill(6'h00); step();
        chk("unstop_fu4", 64'(lane_fu(0)), 64'd4);

        // flush with five buffered results
        do_reset();
        refill(6'h1F); step();
        refill(6'h0F); step();
        chk("preflush_valid", 64'(cdb_valid), 64'hF);
        fu_valid = '0;
        flush = 1; step();
        flush = 0;
        chk("flush_valid", 64'(cdb_valid), 64'h0);
        #1;
        chk("flush_ready", 64'(fu_ready), 64'h3F);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("flush_gone", 64'(cdb_valid), 64'h0);
        end

        // reset mid-traffic with stop high
        for (int c = 0; c < 10; c++) begin refill(6'($urandom_range(0, 63))); step(); end
        reset = 1; stop = 1; fu_valid = '0; step();
        reset = 0; stop = 0;
        chk("mid_rst_valid", 64'(cdb_valid), 64'h0);
        for (int k = 0; k < NC; k++)
            chk("mid_rst_lane", 64'({cdb_tag[k], cdb_data[k], cdb_rob_tag[k]}), 64'h0);
        new_result(5); step();
        fu_valid = '0; step();
        chk("fu5_valid", 64'(cdb_valid), 64'b0001);
        chk("fu5_lane0", 64'(lane_fu(0)), 64'd5);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 12);
            flush = ($urandom_range(0, 99) < 4);
            refill(6'($urandom_range(0, 63)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-bus arbiter between the execution units and the 4-lane common data bus (CDB). Each functional unit (FU) hands one result per cycle into a private one-entry holding buffer through a valid/ready handshake. Each cycle the arbiter grants up to NUM_CDB buffered results in round-robin order and drives them onto registered CDB lanes. The CDB lanes feed the reservation station wakeup logic, the PRF write port and ROB completion.

## Interface
- NUM_FU, 6, number of requesting functional units
- NUM_CDB, 4, number of CDB broadcast lanes
- TAG_W, 8, physical-register tag width
- DATA_W, 32, result data width
- ROB_W, 7, ROB tag width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- stop  in  1  global pipeline stall
- flush  in  1  synchronous squash of all buffered and in-flight results
- fu_valid  in  NUM_FU  FU i presents a result
- fu_ready  out  NUM_FU  FU i result accepted this edge if fu_valid[i]
- fu_tag [0:NUM_FU-1]  in  TAG_W  destination physical tag
- fu_data [0:NUM_FU-1]  in  DATA_W  result value
- fu_rob_tag [0:NUM_FU-1]  in  ROB_W  ROB entry of the producing instruction
- cdb_valid  out  NUM_CDB  lane k broadcasting (registered)
- cdb_tag [0:NUM_CDB-1]  out  TAG_W  registered
- cdb_data [0:NUM_CDB-1]  out  DATA_W  registered
- cdb_rob_tag [0:NUM_CDB-1]  out  ROB_W  registered

## Operation
- State:
  - per FU: buf_valid, buf_tag, buf_data, buf_rob
  - rr_ptr: ceil(log2 NUM_FU) bits
  - CDB output registers
- Grant (combinational, during cycles with stop=0 and flush=0):
  - Scan FU indices rr_ptr, rr_ptr+1, … mod NUM_FU.
  - The first NUM_CDB FUs with buf_valid=1 are granted, in scan order, to lanes 0, 1, ….
  - Unused lanes get nothing.
- fu_ready[i] = !stop && !flush && (!buf_valid[i] || grant[i]). This allows one result per FU per cycle at full throughput.
- On a clock edge with stop=0 and flush=0:
  - Each granted buffer loads its lane register; cdb_valid[k]=1 for used lanes, 0 for unused lanes.
  - Each granted buffer clears, unless the same edge accepts a new result into it.
  - Any FU with fu_valid & fu_ready loads its buffer.
  - If any grant occurred, rr_ptr = (last granted FU index + 1) mod NUM_FU. If no grant occurred, rr_ptr is unchanged.
- stop=1:
  - fu_ready is all 0.
  - No grants are made.
  - Buffers, rr_ptr and all CDB output registers hold their values, including cdb_valid.
- flush=1 (priority over stop):
  - All buf_valid clear and all cdb_valid clear next edge.
  - fu_ready is 0.
  - rr_ptr is unchanged.
- reset (priority over flush and stop): all buf_valid=0, cdb_valid=0, cdb_tag/data/rob_tag=0, rr_ptr=0.
- Arithmetic: rr_ptr wraps modulo NUM_FU (the counter width is not a power-of-two wrap).
- fu_tag, fu_data and fu_rob_tag are don't-care when fu_valid=0.

## Timing
- Reset values: fu_ready=0 during reset and equals all-ones in the first cycle after reset (with stop=0, flush=0); all cdb_* outputs are 0.
- Latency: a result accepted at edge E0 can appear on the CDB at edge E1 at the earliest, valid in the cycle after E1.
- Each granted result is broadcast for exactly one cycle (absent stop) and is never duplicated or dropped.
- Worst-case wait with all FUs requesting continuously: ceil(NUM_FU/NUM_CDB) grant cycles. With the defaults this is at most 2.
- An FU with fu_valid=1 and fu_ready=0 holds its inputs stable until accepted.

## Test plan
- Reset, then single result: FU2 valid for one cycle with tag 0x15, data 0xDEADBEEF, rob 0x03. After the accept edge, cdb_valid=4'b0001 with lane0 = {0x15, 0xDEADBEEF, 0x03} for one cycle. rr_ptr becomes 3.
- All 6 FUs valid continuously from rr_ptr=0:
  - cycle 1 lanes = FU0, FU1, FU2, FU3;
  - cycle 2 lanes = FU4, FU5, FU0, FU1;
  - then FU2, FU3, FU4, FU5.
  - Every FU is granted 2 of every 3 cycles; there is no starvation, and no result is lost or duplicated (the scoreboard checks tags).
- Back-to-back from one FU: FU0 sends tags 1, 2, 3 on consecutive cycles with others idle. fu_ready[0] stays 1, and the CDB shows tags 1, 2, 3 on lane0 on consecutive cycles.
- stop asserted while cdb_valid=4'b0011 and buffers are occupied:
  - outputs stay 4'b0011 with unchanged data and fu_ready=0;
  - after stop drops, the buffered results are granted the next edge with no loss.
- flush with 5 buffered results and valid CDB lanes: next cycle cdb_valid=0 and all fu_ready=1; none of the flushed tags ever appear.
- Reset mid-traffic, with stop also high: next cycle all outputs are 0 and rr_ptr=0. A subsequent request from FU5 alone is granted on lane0.
